// File: rtl/instr_encoder_loader.sv
// Encodes symbolic lw/sw/R-type/beq requests into RV32I words and streams them
// into consecutive instruction-memory addresses, one write per accepted request.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_kind,
    input  logic [3:0]          req_funct,
    input  logic [4:0]          req_rd,
    input  logic [4:0]          req_rs1,
    input  logic [4:0]          req_rs2,
    input  logic signed [12:0]  req_imm,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [31:0]         wr_data,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] KIND_LW  = 2'b00;
    localparam logic [1:0] KIND_SW  = 2'b01;
    localparam logic [1:0] KIND_R   = 2'b10;
    localparam logic [1:0] KIND_BEQ = 2'b11;

    typedef enum logic [1:0] {LOAD, FULL, ERR} state_t;

    state_t              state;
    state_t              stateNext;
    logic                accept;
    logic                legal;
    logic [31:0]         encWord;
    logic [ADDR_W:0]     countReg;
    logic                fullReg;
    logic                errReg;
    logic                vld_p1;
    logic [ADDR_W-1:0]   wrAddr_p1;
    logic [31:0]         wrData_p1;

    function automatic logic [31:0] encode(
        input logic [1:0]         kind,
        input logic [3:0]         funct,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic signed [12:0] imm
    );
        logic [31:0] word;
        case (kind)
            KIND_LW:  word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            KIND_SW:  word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            KIND_R:   word = {1'b0, funct[3], 5'b00000, rs2, rs1, funct[2:0], rd, 7'b0110011};
            default:  word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        endcase
        return word;
    endfunction

    // Memory offsets must fit 12 bits, branch targets must be halfword aligned,
    // and only add/sub/slt/or/and are supported among R-type ops.
    function automatic logic isLegal(
        input logic [1:0]         kind,
        input logic [3:0]         funct,
        input logic signed [12:0] imm
    );
        logic ok;
        case (kind)
            KIND_LW, KIND_SW: ok = (imm[12] == imm[11]);
            KIND_BEQ:         ok = !imm[0];
            default: begin
                ok = (funct[2:0] == 3'b000) || (funct[2:0] == 3'b010) ||
                     (funct[2:0] == 3'b110) || (funct[2:0] == 3'b111);
                if (funct[3] && (funct[2:0] != 3'b000)) ok = 1'b0;
            end
        endcase
        return ok;
    endfunction

    always_comb begin
        req_ready = (state == LOAD) && !rst && !clear;
        accept    = req_valid && req_ready;
        legal     = isLegal(req_kind, req_funct, req_imm);
        encWord   = encode(req_kind, req_funct, req_rd, req_rs1, req_rs2, req_imm);
        stateNext = state;
        if (clear) begin
            stateNext = LOAD;
        end else if (accept) begin
            if (!legal) begin
                stateNext = ERR;
            end else if (countReg == LAST_COUNT) begin
                stateNext = FULL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            countReg <= '0;
            fullReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            state <= stateNext;
            if (clear) begin
                countReg <= '0;
                fullReg  <= 1'b0;
                errReg   <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    countReg <= countReg + 1'b1;
                    fullReg  <= (countReg == LAST_COUNT);
                end else begin
                    errReg <= 1'b1;
                end
            end
        end
    end

    // p1: registered write port, valid for the single cycle after the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            wrAddr_p1 <= '0;
            wrData_p1 <= '0;
        end else begin
            vld_p1 <= accept && legal;
            if (accept && legal) begin
                wrAddr_p1 <= BASE + countReg[ADDR_W-1:0];
                wrData_p1 <= encWord;
            end
        end
    end

    assign wr_en   = vld_p1;
    assign wr_addr = wrAddr_p1;
    assign wr_data = wrData_p1;
    assign count   = countReg;
    assign full    = fullReg;
    assign err     = errReg;

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the single-cycle RISC-V core. It accepts symbolic instruction requests (lw, sw, R-type, beq plus register and immediate fields) over a valid/ready handshake and encodes each one into a 32-bit RV32I machine word. It writes the encoded words into consecutive instruction-memory word addresses. This is the producing end of the opcode/field encoding that the core's control decoder consumes, and it is used by the boot/test harness to load programs before the core runs.

## Interface
Parameters:
- ADDR_W, 6, word-address width of the instruction memory; depth DEPTH = 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first loaded instruction; the address wraps modulo DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- clear  input  1  synchronous restart: count←0, err←0, state←LOAD.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_kind  input  2  00 lw, 01 sw, 10 R-type, 11 beq.
- req_funct  input  4  R-type only: {funct7[5], funct3}.
- req_rd, req_rs1, req_rs2  input  5 each  register numbers.
- req_imm  input  13  signed immediate in two's complement.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written since reset or clear.
- full  output  1  count == DEPTH.
- err  output  1  sticky flag for an illegal request.

## Operation
- FSM states:
  - LOAD: req_ready=1.
  - FULL: req_ready=0.
  - ERR: req_ready=0.
- Transitions:
  - LOAD→FULL when an accept brings count to DEPTH.
  - LOAD→ERR on an illegal accepted request.
  - FULL and ERR exit only via clear or rst, back to LOAD.
- Accept means req_valid & req_ready at the rising edge. req_ready is 0 while rst or clear is high.
- Encodings use funct3 010 for lw/sw and 000 for beq:
  - lw: {imm[11:0], rs1, 010, rd, 0000011}.
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - R-type: {0,funct[3],00000, rs2, rs1, funct[2:0], rd, 0110011}.
  - beq: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
- Illegal requests:
  - lw/sw with imm[12] ≠ imm[11], i.e. the value does not fit in 12 bits.
  - beq with imm[0]=1.
  - R-type funct3 outside {000,010,110,111}.
  - funct[3]=1 with funct3 ≠ 000. Only add, sub, slt, or and and are legal.
- On an illegal accept: no write, count unchanged, err←1, state←ERR.
- On a legal accept: wr_addr←(BASE_ADDR+count) mod DEPTH, wr_data←encoding, wr_en←1 in the next cycle, and count increments at the accepting edge.
- Fields that a kind does not use are ignored (e.g. rd for sw/beq, funct for non-R).
- rd=0 is legal and is encoded as given.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0, req_ready=0 while rst is high, state=LOAD.
- Latency: an accept at edge N drives wr_en/wr_addr/wr_data valid for exactly the cycle after edge N. wr_en drops at N+1 unless another legal accept occurs at N+1.
- Throughput: one instruction per cycle. Back-to-back accepts produce a continuous wr_en with consecutive addresses.
- wr_addr and wr_data hold their last values while wr_en=0.
- full and count are registered and update at the accepting edge. req_ready deasserts in the cycle after the DEPTH-th accept.
- clear and req_valid in the same cycle: clear wins and the request is not accepted. A write already registered from the previous edge still completes.
- Asserting rst mid-stream aborts any pending write immediately, asynchronously clearing wr_en.
- Address wrap: with BASE_ADDR ≠ 0, addresses wrap past DEPTH−1 to 0. Writes never exceed DEPTH because of FULL.

## Test plan
- Reset release, then lw rd=5 rs1=2 imm=8 → one cycle later wr_en=1, wr_addr=0, wr_data=0x00812283, count=1.
- Back-to-back sw rs2=5 rs1=2 imm=12; add rd=3 rs1=1 rs2=2; sub with the same fields; beq rs1=1 rs2=2 imm=−4 → consecutive-cycle writes at addresses 0..3 of 0x00512623, 0x002081B3, 0x402081B3, 0xFE208EE3.
- Illegal requests:
  - beq with imm=3 → no wr_en, err=1, req_ready=0.
  - A subsequent valid request is not accepted.
  - clear → err=0, count=0, req_ready=1.
- ADDR_W=2: five legal requests held valid → four writes at addresses 0..3, full=1, count=4, fifth request stalled until clear.
- BASE_ADDR=3, ADDR_W=2: three writes → addresses 3, 0, 1.
- Asynchronous rst asserted mid-cycle, immediately after an accept → wr_en=0 without waiting for a clock edge, count=0, and no write is observed.
